vram_arbiter: RTL and testbench

Shares one single-port synchronous video RAM between the VGA scan-out fetch path and the Arduino-side command writer in the arduino-gpu-vga design. Display reads have absolute priority and fixed latency, so the 640x480 timing at 25 MHz is never disturbed. Host writes are buffered in a small FIFO and drained into free memory cycles. A sticky flag reports write starvation.

---
 rtl/vram_arbiter.sv | 136 +++++++++++++
 tb/tb_vram_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//==== vram_arbiter : display-priority VRAM arbiter with buffered host writes ==== rev 1.0 ====
module vram_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        host_wr_valid,
  output logic                        host_wr_ready,
  input  logic [ADDR_W-1:0]           host_wr_addr,
  input  logic [DATA_W-1:0]           host_wr_data,
  input  logic                        disp_rd_req,
  input  logic [ADDR_W-1:0]           disp_rd_addr,
  output logic                        disp_rd_valid,
  output logic [DATA_W-1:0]           disp_rd_data,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        wr_starved
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0]  fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic [c_STV_W-1:0] stv_cnt_q, stv_cnt_d;
  logic               starved_q, starved_d;
  logic               mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               rd_v1_q, rd_v2_q, rd_valid_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               w_full, w_empty, w_push, w_pop;

  always_comb begin
    w_full  = (count_q == c_FULL);
    w_empty = (count_q == '0);
    w_push  = host_wr_valid && !w_full;
    // Pops only ever see registered contents, so an empty FIFO never forwards a same-cycle push.
    w_pop   = !disp_rd_req && !w_empty;

    wr_ptr_d = w_push ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + c_CNT_W'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - c_CNT_W'(1);
    end

    mem_en_d    = disp_rd_req || w_pop;
    mem_we_d    = w_pop;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (disp_rd_req) begin
      mem_addr_d = disp_rd_addr;
    end else if (w_pop) begin
      mem_addr_d  = fifo_addr_q[rd_ptr_q];
      mem_wdata_d = fifo_data_q[rd_ptr_q];
    end

    stv_cnt_d = '0;
    if (w_full && disp_rd_req) begin
      stv_cnt_d = (stv_cnt_q == c_STV_MAX) ? stv_cnt_q : stv_cnt_q + c_STV_W'(1);
    end
    starved_d = starved_q || (stv_cnt_d == c_STV_MAX);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_addr_q[wr_ptr_q] <= host_wr_addr;
      fifo_data_q[wr_ptr_q] <= host_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stv_cnt_q   <= '0;
      starved_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_v1_q     <= 1'b0;
      rd_v2_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stv_cnt_q   <= stv_cnt_d;
      starved_q   <= starved_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      // rd_v1 tracks the access cycle, rd_v2 the cycle mem_rdata is valid.
      rd_v1_q     <= disp_rd_req;
      rd_v2_q     <= rd_v1_q;
      rd_valid_q  <= rd_v2_q;
      if (rd_v2_q) begin
        rd_data_q <= mem_rdata;
      end
    end
  end

  assign host_wr_ready = !w_full;
  assign fifo_count    = count_q;
  assign wr_starved    = starved_q;
  assign mem_en        = mem_en_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign disp_rd_valid = rd_valid_q;
  assign disp_rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//==== tb_vram_arbiter : scoreboard bench for vram_arbiter with queue-based reference ==== rev 1.0 ====
module tb_vram_arbiter;
  localparam int DEPTH = 4;
  localparam int LIM   = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_wr_valid = 1'b0, host_wr_ready;
  logic [9:0] host_wr_addr = '0;
  logic [7:0] host_wr_data = '0;
  logic       disp_rd_req = 1'b0, disp_rd_valid;
  logic [9:0] disp_rd_addr = '0;
  logic [7:0] disp_rd_data;
  logic       mem_en, mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata = '0;
  logic [2:0] fifo_count;
  logic       wr_starved;

  vram_arbiter #(.ADDR_W(10), .DATA_W(8), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .disp_rd_req(disp_rd_req), .disp_rd_addr(disp_rd_addr),
    .disp_rd_valid(disp_rd_valid), .disp_rd_data(disp_rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_count(fifo_count), .wr_starved(wr_starved)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [9:0] a; logic [7:0] d; } ev_t;

  logic [7:0] vram    [1024];
  logic [7:0] ref_mem [1024];
  ev_t rq[$], wq[$], mq[$], hq[$], wlog[$];
  int  total = 0, bad = 0, cyc = 0, vcount = 0;
  int  m_sc = 0;
  bit  m_starved = 1'b0;
  bit  mon_en = 1'b0, exp_rdy = 1'b1, exp_stv = 1'b0;
  int  exp_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= vram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic add_host(input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc = 0; e.a = 10'($urandom_range(0, 15)); e.d = 8'($urandom);
      hq.push_back(e);
    end
  endtask

  // One clock cycle of stimulus plus the reference model's view of that cycle.
  task automatic cycle(input bit req, input bit hv, input bit r, input int raddr);
    ev_t e;
    logic [9:0] ra;
    bit full, acc;
    @(posedge clk); #1;
    if (m_sc == LIM - 1) chk("starve_below_limit", wr_starved, 1'b0);
    if (m_sc == LIM)     chk("starve_at_limit", wr_starved, 1'b1);
    exp_cnt = mq.size();
    exp_rdy = (mq.size() < DEPTH);
    exp_stv = m_starved;
    mon_en  = 1'b1;
    ra = (raddr < 0) ? 10'($urandom_range(0, 15)) : 10'(raddr);
    rst = r; disp_rd_req = req; disp_rd_addr = ra;
    host_wr_valid = hv && (hq.size() > 0);
    host_wr_addr  = host_wr_valid ? hq[0].a : 10'($urandom);
    host_wr_data  = host_wr_valid ? hq[0].d : 8'($urandom);
    if (r) begin
      while (rq.size() > 0 && rq[rq.size()-1].cyc > cyc) void'(rq.pop_back());
      while (wq.size() > 0 && wq[wq.size()-1].cyc > cyc) void'(wq.pop_back());
      mq.delete(); hq.delete();
      m_sc = 0; m_starved = 1'b0;
    end else begin
      full = (mq.size() == DEPTH);
      acc  = host_wr_valid && !full;
      if (req) begin
        e.cyc = cyc + 3; e.a = ra; e.d = ref_mem[ra];
        rq.push_back(e);
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        ref_mem[e.a] = e.d;
        e.cyc = cyc + 1;
        wq.push_back(e);
      end
      if (acc) mq.push_back(hq.pop_front());
      if (full && req) begin
        if (m_sc < LIM) m_sc++;
      end else begin
        m_sc = 0;
      end
      if (m_sc == LIM) m_starved = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    bit ev, ew;
    ev_t e;
    if (mon_en) begin
      chk("fifo_count", fifo_count, exp_cnt);
      chk("host_wr_ready", host_wr_ready, exp_rdy);
      chk("wr_starved", wr_starved, exp_stv);
      if (disp_rd_valid) vcount++;
      if (mem_en && mem_we) begin
        e.cyc = cyc; e.a = mem_addr; e.d = mem_wdata;
        wlog.push_back(e);
      end
      ev = (rq.size() > 0) && (rq[0].cyc == cyc);
      chk("disp_rd_valid", disp_rd_valid, ev);
      if (ev) begin
        e = rq.pop_front();
        if (disp_rd_valid) chk("disp_rd_data", disp_rd_data, e.d);
      end
      ew = (wq.size() > 0) && (wq[0].cyc == cyc);
      chk("mem_write", mem_en && mem_we, ew);
      if (ew) begin
        e = wq.pop_front();
        if (mem_en && mem_we) begin
          chk("mem_waddr", mem_addr, e.a);
          chk("mem_wdata", mem_wdata, e.d);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      vram[i] = 8'(i * 7) ^ 8'h3C;
      ref_mem[i] = vram[i];
    end
    vram[5] = 8'hA5; ref_mem[5] = 8'hA5;

    // Reset values
    repeat (3) cycle(0, 0, 1, -1);
    cycle(0, 0, 0, -1);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 10'd0);
    chk("rst_mem_wdata", mem_wdata, 8'd0);
    chk("rst_rd_valid", disp_rd_valid, 1'b0);
    chk("rst_rd_data", disp_rd_data, 8'd0);
    chk("rst_starved", wr_starved, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_ready", host_wr_ready, 1'b1);

    // Read latency on preloaded address 5
    repeat (8) cycle(0, 0, 0, -1);
    vcount = 0;
    cycle(1, 0, 0, 5);
    repeat (6) cycle(0, 0, 0, -1);
    chk("single_read_pulses", vcount, 1);

    // Drain held off by continuous reads
    for (int i = 1; i <= 4; i++) begin
      ev_t e;
      e.cyc = 0; e.a = 10'(i); e.d = 8'(i * 17);
      hq.push_back(e);
    end
    wlog.delete();
    repeat (20) cycle(1, 1, 0, -1);
    chk("drain_blocked_writes", wlog.size(), 0);
    chk("drain_full_count", fifo_count, 3'd4);
    chk("drain_full_ready", host_wr_ready, 1'b0);
    repeat (8) cycle(0, 0, 0, -1);
    chk("drain_nwrites", wlog.size(), 4);
    for (int i = 0; i < wlog.size() && i < 4; i++) begin
      chk("drain_order", wlog[i].a, i + 1);
      chk("drain_consecutive", wlog[i].cyc, wlog[0].cyc + i);
    end
    chk("drain_empty", fifo_count, 3'd0);

    // Interleaved reads and host stream
    for (int i = 0; i < 60; i++) begin
      if (hq.size() < 2) add_host(4);
      cycle(i % 2 == 0, 1, 0, -1);
    end
    hq.delete();
    repeat (10) cycle(0, 0, 0, -1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if (hq.size() < 2) add_host(4);
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 0, -1);
    end
    hq.delete();
    repeat (10) cycle(0, 0, 0, -1);

    // Starvation
    add_host(6);
    repeat (75) cycle(1, 1, 0, -1);
    hq.delete();
    repeat (10) cycle(0, 0, 0, -1);
    chk("starve_sticky", wr_starved, 1'b1);
    repeat (2) cycle(0, 0, 1, -1);
    cycle(0, 0, 0, -1);
    chk("starve_cleared", wr_starved, 1'b0);

    // Reset with writes queued and reads in flight
    add_host(3);
    repeat (4) cycle(1, 1, 0, -1);
    cycle(1, 0, 0, -1);
    cycle(1, 0, 0, -1);
    cycle(0, 0, 1, -1);
    cycle(0, 0, 0, -1);
    wlog.delete();
    vcount = 0;
    repeat (10) cycle(0, 0, 0, -1);
    chk("midrst_no_write", wlog.size(), 0);
    chk("midrst_no_valid", vcount, 0);
    chk("midrst_count", fifo_count, 3'd0);

    chk("rd_scoreboard_drained", rq.size(), 0);
    chk("wr_scoreboard_drained", wq.size(), 0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
